control_fsm: RTL
================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: opcode  input  4  instruction[15:12], sampled from the instruction register.
REQ-004 SHALL have ports: zero  input  1  ALU zero flag; mem_ready  input  1  memory access complete this cycle.
REQ-005 SHALL have ports, each output 1 bit: IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BranchNe, RegWrite, RegDst, MemtoReg, ALUSrcA, PCSrc, Reg3Sel.
REQ-006 SHALL have ports, each output 2 bits: ALUSrcB, ExtSel, Reg1Sel, ALUOp.
REQ-007 SHALL have ports: halted  output  1  processor stopped; illegal  output  1  sticky undefined-opcode flag.

Function
REQ-008 SHALL be a Moore FSM: outputs depend only on state and latched opcode; any output not listed for a state SHALL be 0.
REQ-009 SHALL latch opcode in DECODE and use the latched copy in all later states of the instruction.
REQ-010 SHALL decode opcode classes: R-ALU = 0000, 0110, 0111, 1001, 1101; I-LOGIC = 1010, 1110; ADDI = 0100; LW = 0001; SW = 0010; JUMP = 0011; BEQ = 1000; BNE = 1011; HALT = 1100; undefined = 0101, 1111.
REQ-011 SHALL drive ExtSel = 00 for I-LOGIC, 10 for JUMP, and 01 otherwise, in every state.
REQ-012 SHALL drive Reg1Sel = 01 for LW/SW, 10 for ADDI/BEQ/BNE/HALT/undefined, and 00 otherwise; Reg3Sel = ~opcode[2].
REQ-013 SHALL implement these states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP, HALT.
REQ-014 FETCH: SHALL drive MemRead=1, IorD=0, IRWrite=mem_ready, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=0, PCWrite=mem_ready; SHALL stay in FETCH while mem_ready=0, else go to DECODE.
REQ-015 DECODE: SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, computing the branch/jump target into ALUOut; next state SHALL be LW/SW->MEMADR, R-ALU->EXEC_R, I-LOGIC/ADDI->EXEC_I, BEQ/BNE->BRANCH, JUMP->JUMP, HALT/undefined->HALT.
REQ-016 MEMADR: SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEMRD for LW, MEMWR for SW.
REQ-017 MEMRD: SHALL drive MemRead=1, IorD=1; SHALL hold until mem_ready=1, then go to MEMWB.
REQ-018 MEMWB: SHALL drive RegWrite=1, MemtoReg=1, RegDst=0; next state FETCH.
REQ-019 MEMWR: SHALL drive MemWrite=1, IorD=1; SHALL hold until mem_ready=1, then go to FETCH.
REQ-020 EXEC_R: SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to ALUWB; EXEC_I: SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=11, then go to ALUWB.
REQ-021 ALUWB: SHALL drive RegWrite=1, MemtoReg=0, RegDst=1 for R-ALU and 0 for immediates; next state FETCH.
REQ-022 BRANCH: SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=1, BranchNe=1 for BNE; next state FETCH.
REQ-023 JUMP: SHALL drive PCWrite=1, PCSrc=1; next state FETCH.
REQ-024 HALT: SHALL drive halted=1 with all strobes 0, and SHALL remain in HALT until reset.
REQ-025 SHALL set illegal=1 on entering HALT from an undefined opcode; illegal SHALL hold until reset.
REQ-026 Latency: LW = 5 cycles with zero memory wait; SW and R/I-type = 4; BEQ/BNE/JUMP = 3; each mem_ready=0 cycle SHALL add exactly 1 cycle.
REQ-027 SHALL never assert MemRead and MemWrite in the same cycle, and SHALL never assert PCWrite and PCWriteCond together.

Reset
REQ-028 With reset=1 at a rising edge, state SHALL become FETCH and illegal, halted, and the latched opcode SHALL become 0, including mid-instruction or during a memory wait.
REQ-029 While reset=1, all strobes (MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite) SHALL be forced to 0; the first fetch occurs in the cycle after reset deasserts.

Structure
REQ-030 The state encoding, opcode constants and class decode SHALL reside in a shared package cpu_pkg, also used by the datapath select-line logic.
REQ-031 Opcode classification SHALL be a sub-module opcode_decode (combinational, class one-hot out); the rest SHALL stay in control_fsm.

Verification
REQ-032 Reset mid-MEMRD: reset=1 for 1 cycle -> next cycle state FETCH, MemRead=0 during reset, MemRead=1 after.
REQ-033 LW (0001) with mem_ready low for 2 cycles in MEMRD -> 7 cycles FETCH-to-FETCH; RegWrite=1 and MemtoReg=1 only in MEMWB.
REQ-034 BNE (1011), zero=0 -> BRANCH asserts PCWriteCond=1, BranchNe=1, PCSrc=1; back to FETCH after 3 cycles.
REQ-035 R-ALU 0110 -> ALUSrcB=00, ALUOp=10, then RegDst=1, RegWrite=1; I-LOGIC 1010 -> ExtSel=00, RegDst=0.
REQ-036 Opcode 1111 -> HALT, halted=1, illegal=1, stays for 20 cycles with no strobes; reset clears both flags.
REQ-037 JUMP 0011 -> ExtSel=10, DECODE ALUSrcB=11, JUMP state PCWrite=1 and PCSrc=1; 3 cycles total.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared multicycle-CPU control definitions: FSM states, opcodes, class decode, select encodings.
// Latency: pure declarations and combinational helpers.
// Backpressure: none.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ALUWB,
        ST_BRANCH,
        ST_JUMP,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_LW   = 4'b0001;
    localparam logic [3:0] OP_SW   = 4'b0010;
    localparam logic [3:0] OP_JUMP = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1100;

    // One-hot instruction class; exactly one field is set for any opcode.
    typedef struct packed {
        logic ralu;
        logic ilogic;
        logic addi;
        logic lw;
        logic sw;
        logic jump;
        logic beq;
        logic bne;
        logic halt;
        logic undef;
    } op_class_t;

    function automatic op_class_t classify(input logic [3:0] op);
        op_class_t c;
        c = '0;
        case (op)
            4'b0000, 4'b0110, 4'b0111, 4'b1001, 4'b1101: c.ralu   = 1'b1;
            4'b1010, 4'b1110:                            c.ilogic = 1'b1;
            OP_ADDI: c.addi = 1'b1;
            OP_LW:   c.lw   = 1'b1;
            OP_SW:   c.sw   = 1'b1;
            OP_JUMP: c.jump = 1'b1;
            OP_BEQ:  c.beq  = 1'b1;
            OP_BNE:  c.bne  = 1'b1;
            OP_HALT: c.halt = 1'b1;
            default: c.undef = 1'b1;
        endcase
        return c;
    endfunction

    // Immediate extension: 00 zero-extend (logic ops), 10 jump target, 01 sign-extend.
    function automatic logic [1:0] ext_sel(input op_class_t c);
        if (c.ilogic)    return 2'b00;
        else if (c.jump) return 2'b10;
        else             return 2'b01;
    endfunction

    function automatic logic [1:0] reg1_sel(input op_class_t c);
        if (c.lw || c.sw)                                     return 2'b01;
        else if (c.addi || c.beq || c.bne || c.halt || c.undef) return 2'b10;
        else                                                  return 2'b00;
    endfunction

endpackage

// File: rtl/opcode_decode.sv
// Opcode to one-hot instruction class.
// Latency: combinational.
// Backpressure: none.
module opcode_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  op_class
);

    assign op_class = classify(opcode);

endmodule

// File: rtl/control_fsm.sv
// Moore control FSM for the multicycle CPU datapath.
// Latency: 3-5 cycles per instruction plus one per memory wait cycle.
// Backpressure: FETCH/MEMRD/MEMWR hold while mem_ready is low.
module control_fsm
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       PCSrc,
    output logic       Reg3Sel,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ExtSel,
    output logic [1:0] Reg1Sel,
    output logic [1:0] ALUOp,
    output logic       halted,
    output logic       illegal
);

    state_t     state, next_state;
    logic [3:0] op_q;
    logic [3:0] eff_op;
    logic       illegal_q;
    op_class_t  cls;

    // The zero flag is combined with PCWriteCond/BranchNe in the datapath.
    logic unused_zero;
    assign unused_zero = zero;

    // IR is stable during DECODE, so use it live there; later states see the latched copy.
    assign eff_op = (state == ST_DECODE) ? opcode : op_q;

    opcode_decode u_decode (
        .opcode   (eff_op),
        .op_class (cls)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_FETCH;
            op_q      <= 4'b0000;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_DECODE) begin
                op_q <= opcode;
                if (cls.undef)
                    illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state  = state;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        PCSrc       = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        halted      = 1'b0;
        ExtSel      = ext_sel(cls);
        Reg1Sel     = reg1_sel(cls);
        Reg3Sel     = ~eff_op[2];

        case (state)
            ST_FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                ALUSrcB = 2'b01;
                if (mem_ready)
                    next_state = ST_DECODE;
            end
            ST_DECODE: begin
                ALUSrcB = 2'b11;
                if (cls.lw || cls.sw)           next_state = ST_MEMADR;
                else if (cls.ralu)              next_state = ST_EXEC_R;
                else if (cls.ilogic || cls.addi) next_state = ST_EXEC_I;
                else if (cls.beq || cls.bne)    next_state = ST_BRANCH;
                else if (cls.jump)              next_state = ST_JUMP;
                else if (cls.halt || cls.undef) next_state = ST_HALT;
            end
            ST_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = cls.lw ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)
                    next_state = ST_MEMWB;
            end
            ST_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                next_state = ST_FETCH;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready)
                    next_state = ST_FETCH;
            end
            ST_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                next_state = ST_ALUWB;
            end
            ST_EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = 2'b11;
                next_state = ST_ALUWB;
            end
            ST_ALUWB: begin
                RegWrite   = 1'b1;
                RegDst     = cls.ralu;
                next_state = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSrc       = 1'b1;
                BranchNe    = cls.bne;
                next_state  = ST_FETCH;
            end
            ST_JUMP: begin
                PCWrite    = 1'b1;
                PCSrc      = 1'b1;
                next_state = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: next_state = ST_FETCH;
        endcase

        // No memory or architectural writes may escape while reset is held.
        if (reset) begin
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign illegal = illegal_q;

endmodule
